// File: rtl/master_system.sv
`default_nettype none
// ============================================================================
// Module      : master_system
// Description : WIDTH-bit accumulator datapath. A combinational ALU combines
//               operands A and B under a 4-bit opcode. When load_acc is high,
//               the rising clock edge captures the result, the carry/borrow
//               and the zero flag into the accumulator.
//               Optional build macro SAT_ARITH_EN: add/increment clamp to
//               all-ones on carry, and subtract/decrement clamp to zero on
//               borrow. CarryOut is unaffected by the macro.
// Revision    : 1.0 - initial release
// ============================================================================
module master_system #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clb,
  input  logic             load_acc,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic [WIDTH-1:0] acc_out,
  output logic             CarryOut,
  output logic             Z
);

  // Opcode map
  localparam logic [3:0] c_OP_PASS_A = 4'b0000;
  localparam logic [3:0] c_OP_ADD    = 4'b0001;
  localparam logic [3:0] c_OP_SUB    = 4'b0010;
  localparam logic [3:0] c_OP_NOR    = 4'b0011;
  localparam logic [3:0] c_OP_AND    = 4'b0100;
  localparam logic [3:0] c_OP_OR     = 4'b0101;
  localparam logic [3:0] c_OP_EQ     = 4'b0110;
  localparam logic [3:0] c_OP_XOR    = 4'b0111;
  localparam logic [3:0] c_OP_LT     = 4'b1000;
  localparam logic [3:0] c_OP_GT     = 4'b1001;
  localparam logic [3:0] c_OP_NOT_A  = 4'b1010;
  localparam logic [3:0] c_OP_SHL    = 4'b1011;
  localparam logic [3:0] c_OP_SHR    = 4'b1100;
  localparam logic [3:0] c_OP_INC    = 4'b1101;
  localparam logic [3:0] c_OP_DEC    = 4'b1110;
  localparam logic [3:0] c_OP_PASS_B = 4'b1111;

  localparam logic [WIDTH:0]   c_ONE_EXT  = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] c_ZERO     = '0;
  localparam logic [WIDTH-1:0] c_ALL_ONES = '1;
  localparam logic [WIDTH-2:0] c_PAD      = '0;

  // One extra bit on each arithmetic path: it holds the carry for add/inc
  // and goes high on borrow for sub/dec (the unsigned difference wraps).
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;

  logic [WIDTH-1:0] acc_d,   acc_q;
  logic             carry_d, carry_q;
  logic             zero_d,  zero_q;

  // Extended-width arithmetic shared by the ALU cases below
  always_comb begin
    w_add = {1'b0, A} + {1'b0, B};
    w_sub = {1'b0, A} - {1'b0, B};
    w_inc = {1'b0, A} + c_ONE_EXT;
    w_dec = {1'b0, A} - c_ONE_EXT;
  end

  // ALU: result and carry/borrow selected by opcode; illegal opcodes pass A
  always_comb begin
    w_res   = A;
    w_carry = 1'b0;
    case (ALU_Sel)
      c_OP_PASS_A: w_res = A;
      c_OP_ADD: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
`ifdef SAT_ARITH_EN
        if (w_add[WIDTH]) w_res = c_ALL_ONES;
`endif
      end
      c_OP_SUB: begin
        w_res   = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
`ifdef SAT_ARITH_EN
        if (w_sub[WIDTH]) w_res = c_ZERO;
`endif
      end
      c_OP_NOR:    w_res = ~(A | B);
      c_OP_AND:    w_res = A & B;
      c_OP_OR:     w_res = A | B;
      c_OP_EQ:     w_res = {c_PAD, (A == B)};
      c_OP_XOR:    w_res = A ^ B;
      c_OP_LT:     w_res = {c_PAD, (A < B)};
      c_OP_GT:     w_res = {c_PAD, (A > B)};
      c_OP_NOT_A:  w_res = ~A;
      c_OP_SHL: begin
        w_res   = {A[WIDTH-2:0], 1'b0};
        w_carry = A[WIDTH-1];
      end
      c_OP_SHR: begin
        w_res   = {1'b0, A[WIDTH-1:1]};
        w_carry = A[0];
      end
      c_OP_INC: begin
        w_res   = w_inc[WIDTH-1:0];
        w_carry = w_inc[WIDTH];
`ifdef SAT_ARITH_EN
        if (w_inc[WIDTH]) w_res = c_ALL_ONES;
`endif
      end
      c_OP_DEC: begin
        w_res   = w_dec[WIDTH-1:0];
        w_carry = w_dec[WIDTH];
`ifdef SAT_ARITH_EN
        if (w_dec[WIDTH]) w_res = c_ZERO;
`endif
      end
      c_OP_PASS_B: w_res = B;
      default: begin
        w_res   = A;
        w_carry = 1'b0;
      end
    endcase
  end

  // Next accumulator state: capture the ALU output on load, otherwise hold
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (load_acc) begin
      acc_d   = w_res;
      carry_d = w_carry;
      zero_d  = (w_res == c_ZERO);
    end
  end

  // Accumulator register; the clear-bar input takes priority over load
  always_ff @(posedge clk) begin
    if (!clb) begin
      acc_q   <= c_ZERO;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign acc_out  = acc_q;
  assign CarryOut = carry_q;
  assign Z        = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_master_system.sv
`default_nettype none
// ============================================================================
// Module      : tb_master_system
// Description : Self-checking bench for master_system. Directed scenarios
//               plus randomized traffic, compared against an arithmetic
//               reference model. Honours SAT_ARITH_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_master_system;

  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         clb = 1'b0;
  logic         load_acc = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   ALU_Sel = '0;
  logic [W-1:0] acc_out;
  logic         CarryOut;
  logic         Z;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int exp_acc   = 0;
  int exp_carry = 0;

  master_system #(.WIDTH(W)) u_dut (
    .clk      (clk),
    .clb      (clb),
    .load_acc (load_acc),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .acc_out  (acc_out),
    .CarryOut (CarryOut),
    .Z        (Z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  // Opcode semantics in plain integer arithmetic
  function automatic void ref_alu(input int sel, input int a, input int b,
                                  output int r, output int c);
    r = a;
    c = 0;
    case (sel)
      0:  r = a;
      1:  begin
            r = a + b;
            if (r >= M) begin
              c = 1;
`ifdef SAT_ARITH_EN
              r = M - 1;
`else
              r = r - M;
`endif
            end
          end
      2:  begin
            r = a - b;
            if (r < 0) begin
              c = 1;
`ifdef SAT_ARITH_EN
              r = 0;
`else
              r = r + M;
`endif
            end
          end
      3:  r = (M - 1) - (a | b);
      4:  r = a & b;
      5:  r = a | b;
      6:  r = (a == b) ? 1 : 0;
      7:  r = a ^ b;
      8:  r = (a < b) ? 1 : 0;
      9:  r = (a > b) ? 1 : 0;
      10: r = (M - 1) - a;
      11: begin r = (a * 2) % M; c = (a >= M / 2) ? 1 : 0; end
      12: begin r = a / 2; c = a % 2; end
      13: begin
            r = a + 1;
            if (r == M) begin
              c = 1;
`ifdef SAT_ARITH_EN
              r = M - 1;
`else
              r = 0;
`endif
            end
          end
      14: begin
            r = a - 1;
            if (a == 0) begin
              c = 1;
`ifdef SAT_ARITH_EN
              r = 0;
`else
              r = M - 1;
`endif
            end
          end
      15: r = b;
      default: r = a;
    endcase
  endfunction

  // Apply one cycle of inputs, advance the model at the edge, compare after it
  task automatic step(input bit rst_n, input bit ld, input int a, input int b, input int sel);
    int r, c;
    @(negedge clk);
    clb      = rst_n;
    load_acc = ld;
    A        = W'(a);
    B        = W'(b);
    ALU_Sel  = 4'(sel);
    @(posedge clk);
    if (!rst_n) begin
      exp_acc   = 0;
      exp_carry = 0;
    end else if (ld) begin
      ref_alu(sel, a, b, r, c);
      exp_acc   = r;
      exp_carry = c;
    end
    #1;
    check("acc_out",  acc_out,  exp_acc);
    check("CarryOut", CarryOut, exp_carry);
    check("Z",        Z,        (exp_acc == 0) ? 1 : 0);
  endtask

  initial begin
    int a, b, sel, hold_acc;
    bit rn, ld;

    // Reset overrides load
    step(0, 1, 'h55, 0, 1);
    check("rst_acc", acc_out, 0);
    check("rst_z",   Z,       1);

    step(1, 1, 15, 10, 1);
    check("add_15_10", acc_out, 25);
    check("add_15_10_z", Z, 0);

    step(1, 1, 20, 25, 2);
`ifdef SAT_ARITH_EN
    check("sub_borrow", acc_out, 0);
`else
    check("sub_borrow", acc_out, 'hFB);
`endif
    check("sub_borrow_c", CarryOut, 1);

    step(1, 1, 'hAA, 'h55, 3);
    check("nor_zero", acc_out, 0);
    step(1, 1, 'h0F, 0, 11);
    check("shl", acc_out, 'h1E);
    step(1, 1, 'hF0, 0, 12);
    check("shr", acc_out, 'h78);
    step(1, 1, 10, 20, 8);
    check("lt", acc_out, 1);
    step(1, 1, 30, 30, 6);
    check("eq_true", acc_out, 1);
    step(1, 1, 30, 31, 6);
    check("eq_false", acc_out, 0);

    step(1, 1, 'hFF, 'h01, 1);
`ifdef SAT_ARITH_EN
    check("add_ovf", acc_out, 'hFF);
`else
    check("add_ovf", acc_out, 0);
`endif
    check("add_ovf_c", CarryOut, 1);

    // Hold for three edges with changing operands
    hold_acc = exp_acc;
    for (int i = 0; i < 3; i++) step(1, 0, i * 37 + 5, i * 11 + 3, i + 4);
    check("hold_acc", acc_out, hold_acc);

    // Mid-sequence clear then release
    step(0, 1, 'h12, 0, 0);
    check("mid_rst", acc_out, 0);
    step(1, 1, 'h12, 0, 0);
    check("after_rst", acc_out, 'h12);

    // Boundary: increment/decrement wrap
    step(1, 1, 'hFF, 0, 13);
    step(1, 1, 0, 0, 14);

    // Randomized traffic with biased operand corners
    for (int i = 0; i < 400; i++) begin
      rn  = ($urandom_range(0, 15) != 0);
      ld  = ($urandom_range(0, 3) != 0);
      sel = int'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0:       a = 0;
        1:       a = M - 1;
        default: a = int'($urandom_range(0, M - 1));
      endcase
      case ($urandom_range(0, 5))
        0:       b = a;
        1:       b = int'($urandom_range(0, 1)) * (M - 1);
        default: b = int'($urandom_range(0, M - 1));
      endcase
      step(rn, ld, a, b, sel);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
